// File: rtl/raw_unpack_if.sv
// Byte-stream in / pixel-group out bundle for raw_unpack.
// The master side feeds payload bytes and markers; the slave side returns pixels and status.
interface raw_unpack_if #(
    parameter int NUM_LANES = 2,
    parameter int PIX_W     = 12
) ();
    logic [1:0]             cfg_mode;
    logic                   raw_vld;
    logic [8*NUM_LANES-1:0] raw_data;
    logic                   raw_vsync;
    logic                   raw_lend;
    logic                   pixel_vld;
    logic [4*PIX_W-1:0]     pixel_data;
    logic                   pixel_sol;
    logic                   err_partial;
    logic                   err_mode;

    modport master (
        output cfg_mode, raw_vld, raw_data, raw_vsync, raw_lend,
        input  pixel_vld, pixel_data, pixel_sol, err_partial, err_mode
    );

    modport slave (
        input  cfg_mode, raw_vld, raw_data, raw_vsync, raw_lend,
        output pixel_vld, pixel_data, pixel_sol, err_partial, err_mode
    );
endinterface

// File: rtl/raw_unpack.sv
// Packed RAW8/RAW10/RAW12 payload bytes to four left-justified pixels per beat.
// Define RAW_UNPACK_RAW12_EN to support RAW12; otherwise mode 2 is treated as reserved.
module raw_unpack #(
    parameter int NUM_LANES = 2,
    parameter int PIX_W     = 12
) (
    input logic         clk,
    input logic         resetn,
    raw_unpack_if.slave bus
);
`ifdef RAW_UNPACK_RAW12_EN
    localparam int BUF_BYTES = 12;
`else
    localparam int BUF_BYTES = 8;
`endif
    localparam int BW = 8 * BUF_BYTES;

    typedef enum logic [1:0] {
        MODE_RAW8  = 2'd0,
        MODE_RAW10 = 2'd1,
        MODE_RAW12 = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    mode_e              mode_q;
    logic               frame_valid_q;
    logic               sol_pend_q;
    logic               err_mode_q;
    logic [3:0]         fill_q;
    logic [BW-1:0]      buf_q;
    logic               pixel_vld_q;
    logic               pixel_sol_q;
    logic               err_partial_q;
    logic [4*PIX_W-1:0] pixel_data_q;

    logic               accept;
    logic               lend;
    logic               grp_done;
    logic               part_err;
    logic               rsvd_mode;
    logic [3:0]         grp_bytes;
    logic [3:0]         fill_app;
    logic [3:0]         fill_nx;
    logic [BW-1:0]      keep_mask;
    logic [BW-1:0]      buf_app;
    logic [BW-1:0]      buf_nx;
    logic [47:0]        grp_pix;
    logic [4*PIX_W-1:0] pix_nx;

    // Returns {P0,P1,P2,P3} as 12-bit left-justified pixels from the oldest six bytes.
    function automatic logic [47:0] unpack(input mode_e m, input logic [47:0] grp);
        logic [7:0]  b [6];
        logic [11:0] p [4];
        for (int i = 0; i < 6; i++) b[i] = grp[8*i +: 8];
        for (int i = 0; i < 4; i++) p[i] = {b[i], 4'h0};
        case (m)
            MODE_RAW10: for (int i = 0; i < 4; i++) p[i] = {b[i], b[4][2*i +: 2], 2'b00};
`ifdef RAW_UNPACK_RAW12_EN
            MODE_RAW12: begin
                p[0] = {b[0], b[2][3:0]};
                p[1] = {b[1], b[2][7:4]};
                p[2] = {b[3], b[5][3:0]};
                p[3] = {b[4], b[5][7:4]};
            end
`endif
            default: ;
        endcase
        return {p[0], p[1], p[2], p[3]};
    endfunction

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        accept    = frame_valid_q && !err_mode_q && bus.raw_vld && !bus.raw_vsync;
        lend      = bus.raw_lend && !bus.raw_vsync;
        keep_mask = ~({BW{1'b1}} << {fill_q, 3'b000});
        buf_app   = buf_q;
        fill_app  = fill_q;
        if (accept) begin
            buf_app  = (buf_q & keep_mask) | (BW'(bus.raw_data) << {fill_q, 3'b000});
            fill_app = fill_q + 4'(NUM_LANES);
        end

        case (mode_q)
            MODE_RAW10: grp_bytes = 4'd5;
`ifdef RAW_UNPACK_RAW12_EN
            MODE_RAW12: grp_bytes = 4'd6;
`endif
            default:    grp_bytes = 4'd4;
        endcase

        grp_done = accept && (fill_app >= grp_bytes);
        buf_nx   = buf_app;
        fill_nx  = fill_app;
        if (grp_done) begin
            buf_nx  = buf_app >> {grp_bytes, 3'b000};
            fill_nx = fill_app - grp_bytes;
        end
        // Line end is applied after the group extraction, so only true leftovers count.
        part_err = lend && (fill_nx != 4'd0);
        if (lend) fill_nx = 4'd0;

        grp_pix = unpack(mode_q, buf_app[47:0]);
        pix_nx  = '0;
        for (int i = 0; i < 4; i++) pix_nx[i*PIX_W +: PIX_W] = PIX_W'(grp_pix[i*12 +: 12]) << (PIX_W - 12);

`ifdef RAW_UNPACK_RAW12_EN
        rsvd_mode = (bus.cfg_mode == MODE_RSVD);
`else
        rsvd_mode = bus.cfg_mode[1];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mode_q        <= MODE_RAW8;
            frame_valid_q <= 1'b0;
            sol_pend_q    <= 1'b1;
            err_mode_q    <= 1'b0;
            fill_q        <= 4'd0;
            pixel_vld_q   <= 1'b0;
            pixel_sol_q   <= 1'b0;
            err_partial_q <= 1'b0;
            pixel_data_q  <= '0;
        end else begin
            pixel_vld_q   <= grp_done;
            pixel_sol_q   <= grp_done && sol_pend_q;
            err_partial_q <= part_err;
            if (grp_done) pixel_data_q <= pix_nx;

            if (bus.raw_vsync) begin
                fill_q        <= 4'd0;
                mode_q        <= mode_e'(bus.cfg_mode);
                frame_valid_q <= 1'b1;
                sol_pend_q    <= 1'b1;
                err_mode_q    <= rsvd_mode;
            end else begin
                fill_q <= fill_nx;
                if (lend)          sol_pend_q <= 1'b1;
                else if (grp_done) sol_pend_q <= 1'b0;
            end
        end
    end

    // NOTE: the byte buffer has no reset; fill_q alone decides which bytes are meaningful.
    always_ff @(posedge clk) begin
        buf_q <= buf_nx;
    end

    assign bus.pixel_vld   = pixel_vld_q;
    assign bus.pixel_sol   = pixel_sol_q;
    assign bus.pixel_data  = pixel_data_q;
    assign bus.err_partial = err_partial_q;
    assign bus.err_mode    = err_mode_q;
endmodule

// File: tb/tb_raw_unpack.sv
// Directed bench for raw_unpack: a 2-lane and a 1-lane instance side by side.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_raw_unpack;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   vcnt2 = 0;
    int   pcnt2 = 0;
    int   vcnt1 = 0;

    always #5 clk = ~clk;

    raw_unpack_if #(.NUM_LANES(2), .PIX_W(12)) if2 ();
    raw_unpack_if #(.NUM_LANES(1), .PIX_W(12)) if1 ();

    raw_unpack #(.NUM_LANES(2), .PIX_W(12)) u_dut2 (.clk(clk), .resetn(resetn), .bus(if2));
    raw_unpack #(.NUM_LANES(1), .PIX_W(12)) u_dut1 (.clk(clk), .resetn(resetn), .bus(if1));

    always @(negedge clk) begin
        if (if2.pixel_vld === 1'b1)   vcnt2++;
        if (if2.err_partial === 1'b1) pcnt2++;
        if (if1.pixel_vld === 1'b1)   vcnt1++;
    end

    task automatic beat2(input logic vld, input logic [15:0] data, input logic vsync,
                         input logic lend, input logic [1:0] mode);
        @(negedge clk);
        if2.raw_vld = vld; if2.raw_data = data; if2.raw_vsync = vsync;
        if2.raw_lend = lend; if2.cfg_mode = mode;
        @(posedge clk); #1;
        if2.raw_vld = 1'b0; if2.raw_data = '0; if2.raw_vsync = 1'b0; if2.raw_lend = 1'b0;
    endtask

    task automatic beat1(input logic vld, input logic [7:0] data, input logic vsync,
                         input logic lend, input logic [1:0] mode);
        @(negedge clk);
        if1.raw_vld = vld; if1.raw_data = data; if1.raw_vsync = vsync;
        if1.raw_lend = lend; if1.cfg_mode = mode;
        @(posedge clk); #1;
        if1.raw_vld = 1'b0; if1.raw_data = '0; if1.raw_vsync = 1'b0; if1.raw_lend = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int c;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({if2.pixel_vld, if2.pixel_sol, if2.err_partial, if2.err_mode} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags2 got %b want 0000", {if2.pixel_vld, if2.pixel_sol, if2.err_partial, if2.err_mode});
        end
        checks++;
        if (if2.pixel_data !== 48'h0) begin
            errors++; $display("FAIL reset_data2 got %h want 0", if2.pixel_data);
        end
        checks++;
        if ({if1.pixel_vld, if1.pixel_data, if1.err_mode} !== 50'h0) begin
            errors++; $display("FAIL reset_dut1 got %h want 0", {if1.pixel_vld, if1.pixel_data, if1.err_mode});
        end
        @(negedge clk) resetn = 1'b1;
        // Beats before the first vsync must be ignored.
        c = vcnt2;
        beat2(1'b1, 16'h2211, 1'b0, 1'b0, 2'd0);
        beat2(1'b1, 16'h4433, 1'b0, 1'b0, 2'd0);
        beat2(1'b1, 16'h6655, 1'b0, 1'b0, 2'd0);
        idle_cycle();
        checks++;
        if (vcnt2 !== c) begin
            errors++; $display("FAIL pre_vsync_ignored got %0d pulses want 0", vcnt2 - c);
        end
    endtask

    task automatic test_raw10();
        beat2(1'b0, 16'h0000, 1'b1, 1'b0, 2'd1);
        beat2(1'b1, 16'h2010, 1'b0, 1'b0, 2'd1);
        beat2(1'b1, 16'h4030, 1'b0, 1'b0, 2'd1);
        checks++;
        if (if2.pixel_vld !== 1'b0) begin
            errors++; $display("FAIL raw10_early got vld %b want 0", if2.pixel_vld);
        end
        beat2(1'b1, 16'h11E4, 1'b0, 1'b0, 2'd1);
        checks++;
        if ({if2.pixel_vld, if2.pixel_sol, if2.pixel_data} !== {2'b11, 48'h100_204_308_40C}) begin
            errors++; $display("FAIL raw10_g0 got %b%b %h want 11 10020430840c", if2.pixel_vld, if2.pixel_sol, if2.pixel_data);
        end
        beat2(1'b1, 16'h3322, 1'b0, 1'b0, 2'd1);
        checks++;
        if (if2.pixel_vld !== 1'b0) begin
            errors++; $display("FAIL raw10_mid got vld %b want 0", if2.pixel_vld);
        end
        beat2(1'b1, 16'h5544, 1'b0, 1'b1, 2'd1);
        checks++;
        if ({if2.pixel_vld, if2.pixel_sol, if2.err_partial, if2.pixel_data} !== {3'b100, 48'h114_224_334_444}) begin
            errors++; $display("FAIL raw10_g1 got %b%b%b %h want 100 114224334444",
                               if2.pixel_vld, if2.pixel_sol, if2.err_partial, if2.pixel_data);
        end
        idle_cycle();
        checks++;
        if ({if2.pixel_vld, if2.pixel_data} !== {1'b0, 48'h114_224_334_444}) begin
            errors++; $display("FAIL raw10_hold got %b %h want 0 114224334444", if2.pixel_vld, if2.pixel_data);
        end
    endtask

    task automatic test_raw8_1lane();
        beat1(1'b0, 8'h00, 1'b1, 1'b0, 2'd0);
        beat1(1'b1, 8'h11, 1'b0, 1'b0, 2'd0);
        beat1(1'b1, 8'h22, 1'b0, 1'b0, 2'd0);
        beat1(1'b1, 8'h33, 1'b0, 1'b0, 2'd0);
        checks++;
        if (if1.pixel_vld !== 1'b0) begin
            errors++; $display("FAIL raw8_early got vld %b want 0", if1.pixel_vld);
        end
        beat1(1'b1, 8'h44, 1'b0, 1'b0, 2'd0);
        checks++;
        if ({if1.pixel_vld, if1.pixel_sol, if1.pixel_data} !== {2'b11, 48'h110_220_330_440}) begin
            errors++; $display("FAIL raw8_1lane got %b%b %h want 11 110220330440", if1.pixel_vld, if1.pixel_sol, if1.pixel_data);
        end
    endtask

    task automatic test_raw12();
        int c;
        beat2(1'b0, 16'h0000, 1'b1, 1'b0, 2'd2);
        c = vcnt2;
        beat2(1'b1, 16'hCDAB, 1'b0, 1'b0, 2'd2);
        beat2(1'b1, 16'h1221, 1'b0, 1'b0, 2'd2);
        beat2(1'b1, 16'h6534, 1'b0, 1'b0, 2'd2);
`ifdef RAW_UNPACK_RAW12_EN
        checks++;
        if ({if2.pixel_vld, if2.err_mode, if2.pixel_data} !== {2'b10, 48'hAB1_CD2_125_346}) begin
            errors++; $display("FAIL raw12 got %b%b %h want 10 ab1cd2125346", if2.pixel_vld, if2.err_mode, if2.pixel_data);
        end
`else
        idle_cycle();
        checks++;
        if ({if2.err_mode, vcnt2 - c} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL raw12_disabled got err_mode %b pulses %0d want 1 0", if2.err_mode, vcnt2 - c);
        end
`endif
    endtask

    task automatic test_partial();
        int p;
        beat2(1'b0, 16'h0000, 1'b1, 1'b0, 2'd1);
        p = pcnt2;
        beat2(1'b1, 16'h2010, 1'b0, 1'b0, 2'd1);
        beat2(1'b1, 16'h4030, 1'b0, 1'b0, 2'd1);
        beat2(1'b1, 16'h11E4, 1'b0, 1'b1, 2'd1);
        checks++;
        if ({if2.pixel_vld, if2.err_partial} !== 2'b11) begin
            errors++; $display("FAIL partial_flag got vld/err %b%b want 11", if2.pixel_vld, if2.err_partial);
        end
        idle_cycle();
        idle_cycle();
        checks++;
        if (pcnt2 - p !== 1) begin
            errors++; $display("FAIL partial_once got %0d pulses want 1", pcnt2 - p);
        end
        // Fresh line: the dropped 0x11 must not leak into the first group.
        beat2(1'b1, 16'h2010, 1'b0, 1'b0, 2'd1);
        beat2(1'b1, 16'h4030, 1'b0, 1'b0, 2'd1);
        beat2(1'b1, 16'h00E4, 1'b0, 1'b0, 2'd1);
        checks++;
        if ({if2.pixel_vld, if2.pixel_sol, if2.pixel_data} !== {2'b11, 48'h100_204_308_40C}) begin
            errors++; $display("FAIL partial_next_line got %b%b %h want 11 10020430840c", if2.pixel_vld, if2.pixel_sol, if2.pixel_data);
        end
    endtask

    task automatic test_reserved();
        int c;
        beat2(1'b0, 16'h0000, 1'b1, 1'b0, 2'd3);
        checks++;
        if (if2.err_mode !== 1'b1) begin
            errors++; $display("FAIL rsvd_err_mode got %b want 1", if2.err_mode);
        end
        c = vcnt2;
        beat2(1'b1, 16'h2211, 1'b0, 1'b0, 2'd3);
        beat2(1'b1, 16'h4433, 1'b0, 1'b0, 2'd3);
        beat2(1'b1, 16'h6655, 1'b0, 1'b0, 2'd3);
        idle_cycle();
        checks++;
        if (vcnt2 - c !== 0) begin
            errors++; $display("FAIL rsvd_no_output got %0d pulses want 0", vcnt2 - c);
        end
        beat2(1'b0, 16'h0000, 1'b1, 1'b0, 2'd0);
        checks++;
        if (if2.err_mode !== 1'b0) begin
            errors++; $display("FAIL rsvd_recover got err_mode %b want 0", if2.err_mode);
        end
        beat2(1'b1, 16'h2211, 1'b0, 1'b0, 2'd0);
        beat2(1'b1, 16'h4433, 1'b0, 1'b0, 2'd0);
        checks++;
        if ({if2.pixel_vld, if2.pixel_sol, if2.pixel_data} !== {2'b11, 48'h110_220_330_440}) begin
            errors++; $display("FAIL rsvd_resume got %b%b %h want 11 110220330440", if2.pixel_vld, if2.pixel_sol, if2.pixel_data);
        end
    endtask

    task automatic test_vsync_discard();
        beat2(1'b1, 16'hAAAA, 1'b1, 1'b0, 2'd0);
        beat2(1'b1, 16'h2211, 1'b0, 1'b0, 2'd0);
        checks++;
        if (if2.pixel_vld !== 1'b0) begin
            errors++; $display("FAIL vsync_discard_early got vld %b want 0", if2.pixel_vld);
        end
        beat2(1'b1, 16'h4433, 1'b0, 1'b0, 2'd0);
        checks++;
        if ({if2.pixel_vld, if2.pixel_data} !== {1'b1, 48'h110_220_330_440}) begin
            errors++; $display("FAIL vsync_discard got %b %h want 1 110220330440", if2.pixel_vld, if2.pixel_data);
        end
    endtask

    task automatic test_reset_mid();
        beat2(1'b0, 16'h0000, 1'b1, 1'b0, 2'd1);
        beat2(1'b1, 16'h2211, 1'b0, 1'b0, 2'd1);
        beat2(1'b1, 16'h4433, 1'b0, 1'b0, 2'd1);
        @(negedge clk) resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({if2.pixel_vld, if2.pixel_sol, if2.err_partial, if2.err_mode, if2.pixel_data} !== 52'h0) begin
            errors++; $display("FAIL reset_mid got %h want 0",
                               {if2.pixel_vld, if2.pixel_sol, if2.err_partial, if2.err_mode, if2.pixel_data});
        end
        @(negedge clk) resetn = 1'b1;
        beat2(1'b0, 16'h0000, 1'b1, 1'b0, 2'd0);
        beat2(1'b1, 16'h4433, 1'b0, 1'b0, 2'd0);
        beat2(1'b1, 16'h6655, 1'b0, 1'b0, 2'd0);
        checks++;
        if ({if2.pixel_vld, if2.pixel_sol, if2.pixel_data} !== {2'b11, 48'h330_440_550_660}) begin
            errors++; $display("FAIL reset_mid_resume got %b%b %h want 11 330440550660", if2.pixel_vld, if2.pixel_sol, if2.pixel_data);
        end
    endtask

    initial begin
        if2.cfg_mode = 2'd0; if2.raw_vld = 1'b0; if2.raw_data = '0; if2.raw_vsync = 1'b0; if2.raw_lend = 1'b0;
        if1.cfg_mode = 2'd0; if1.raw_vld = 1'b0; if1.raw_data = '0; if1.raw_vsync = 1'b0; if1.raw_lend = 1'b0;
        test_reset();
        test_raw10();
        test_raw8_1lane();
        test_raw12();
        test_partial();
        test_reserved();
        test_vsync_discard();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
